// File: rtl/svc_rv_bench_pkg.sv
// Shared types and constants for the svc_rv_soc_sram benchmark harness.
package svc_rv_bench_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        TIMEOUT
    } bench_state_t;

    localparam int CYCLES_W = 32;

endpackage

// File: rtl/svc_rv_bench_ctl.sv
// Run sequencer for the benchmark harness: state machine, run-cycle counter,
// timeout compare and the registered core reset.
module svc_rv_bench_ctl
    import svc_rv_bench_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                ebreak,
    output bench_state_t        state,
    output logic                launch,
    output logic                core_rst_n,
    output logic [CYCLES_W-1:0] cycles
);

    localparam logic [CYCLES_W-1:0] LIMIT = CYCLES_W'(TIMEOUT_CYCLES - 1);

    bench_state_t state_next;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        launch     = 1'b0;
        case (state)
            RUN: begin
                // ebreak has priority over the limit when both land in one cycle
                if (ebreak) begin
                    state_next = DONE;
                end else if (cycles == LIMIT) begin
                    state_next = TIMEOUT;
                end
            end
            default: begin
                if (start) begin
                    state_next = RUN;
                    launch     = 1'b1;
                end
            end
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            core_rst_n <= 1'b0;
            cycles     <= '0;
        end else begin
            state      <= state_next;
            core_rst_n <= (state_next == RUN);
            if (launch) begin
                cycles <= '0;
            end else if (state == RUN && cycles != '1) begin
                cycles <= cycles + 1'b1;
            end
        end
    end

endmodule

// File: rtl/svc_rv_soc_sram.sv
// Compact RV32 subset SoC (lui, addi, jal, lw, sb/sh/sw, ebreak) with IMEM,
// DMEM and an IO store bus; bit 31 clear = IO, 2'b10 = DMEM, 2'b11 = IMEM.
module svc_rv_soc_sram #(
    parameter int XLEN        = 32,
    parameter int IMEM_AW     = 5,
    parameter int DMEM_AW     = 1,
    parameter int PIPELINED   = 1,
    parameter int FWD_REGFILE = 1,
    parameter int FWD         = 1,
    parameter int BPRED       = 1,
    parameter     IMEM_INIT   = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ebreak,
    output logic              io_wen,
    output logic [XLEN-1:0]   io_waddr,
    output logic [XLEN/8-1:0] io_wstrb,
    output logic [XLEN-1:0]   io_wdata,
    input  logic [XLEN-1:0]   io_rdata
);

    localparam int          SW          = XLEN / 8;
    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;
    localparam logic [6:0]  OP_LUI      = 7'h37;
    localparam logic [6:0]  OP_JAL      = 7'h6f;
    localparam logic [6:0]  OP_IMM      = 7'h13;
    localparam logic [6:0]  OP_LOAD     = 7'h03;
    localparam logic [6:0]  OP_STORE    = 7'h23;

    logic [31:0]        imem [2**IMEM_AW];
    logic [XLEN-1:0]    dmem [2**DMEM_AW];
    logic [XLEN-1:0]    regs [32];
    logic [IMEM_AW-1:0] pc;
    logic               bubble;

    logic [31:0]     insn;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i, imm_s, imm_u, imm_j, rs1_val, rs2_val, addr, wb_val, st_data;
    logic [SW-1:0]   st_strb;
    logic            exec, is_store, wr_en, need_bubble;

    assign insn     = imem[pc];
    assign opcode   = insn[6:0];
    assign rd       = insn[11:7];
    assign imm_i    = XLEN'($signed(insn[31:20]));
    assign imm_s    = XLEN'($signed({insn[31:25], insn[11:7]}));
    assign imm_u    = XLEN'($signed({insn[31:12], 12'b0}));
    assign imm_j    = XLEN'($signed({insn[31], insn[19:12], insn[20], insn[30:21], 1'b0}));
    assign rs1_val  = (insn[19:15] == 5'd0) ? '0 : regs[insn[19:15]];
    assign rs2_val  = (insn[24:20] == 5'd0) ? '0 : regs[insn[24:20]];
    assign is_store = (opcode == OP_STORE);
    assign addr     = rs1_val + (is_store ? imm_s : imm_i);
    assign exec     = rst_n && !bubble;

    always_comb begin
        st_data = rs2_val;
        st_strb = '1;
        case (insn[14:12])
            3'b000: begin
                st_data = {SW{rs2_val[7:0]}};
                st_strb = SW'(1) << addr[1:0];
            end
            3'b001: begin
                st_data = {(SW / 2){rs2_val[15:0]}};
                st_strb = SW'(3) << {addr[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        wb_val = '0;
        wr_en  = exec && (rd != 5'd0);
        case (opcode)
            OP_LUI:  wb_val = imm_u;
            OP_IMM:  wb_val = rs1_val + imm_i;
            OP_JAL:  wb_val = XLEN'({pc + 1'b1, 2'b00});
            OP_LOAD: wb_val = addr[XLEN-1] ? dmem[addr[DMEM_AW+1:2]] : io_rdata;
            default: wr_en = 1'b0;
        endcase
    end

    assign io_wen   = exec && is_store && !addr[XLEN-1];
    assign io_waddr = addr;
    assign io_wstrb = st_strb;
    assign io_wdata = st_data;
    assign ebreak   = exec && (insn == EBREAK_INSN);

    // Timing knobs: an unpipelined core, an unpredicted jump or an unforwarded
    // writeback each cost one idle cycle after the instruction.
    assign need_bubble = (PIPELINED == 0)
                      || (opcode == OP_JAL && BPRED == 0)
                      || (wr_en && (FWD == 0 || FWD_REGFILE == 0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= '0;
            bubble <= 1'b0;
        end else if (bubble) begin
            bubble <= 1'b0;
        end else begin
            pc     <= (opcode == OP_JAL) ? pc + IMEM_AW'(imm_j >> 2) : pc + 1'b1;
            bubble <= need_bubble;
        end
    end

    // NOTE: storage arrays carry no reset; software must write before it reads.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            regs[rd] <= wb_val;
        end
        if (exec && is_store && addr[XLEN-1:XLEN-2] == 2'b10) begin
            for (int b = 0; b < SW; b++) begin
                if (st_strb[b]) dmem[addr[DMEM_AW+1:2]][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
        if (exec && is_store && addr[XLEN-1:XLEN-2] == 2'b11) begin
            imem[addr[IMEM_AW+1:2]] <= 32'(st_data);
        end
    end

endmodule

// File: rtl/svc_rv_soc_sram_bench.sv
// Benchmark harness around svc_rv_soc_sram: sequences runs, counts cycles and
// captures IO result words. Define SVC_RV_SOC_BENCH_CHECK_EN for the slot-0 check.
module svc_rv_soc_sram_bench
    import svc_rv_bench_pkg::*;
#(
    parameter int              XLEN           = 32,
    parameter int              IMEM_AW        = 5,
    parameter int              DMEM_AW        = 1,
    parameter int              PIPELINED      = 1,
    parameter int              FWD_REGFILE    = 1,
    parameter int              FWD            = 1,
    parameter int              BPRED          = 1,
    parameter                  IMEM_INIT      = "",
    parameter int              NUM_RESULTS    = 4,
    parameter logic [31:0]     RESULT_BASE    = 32'h0000_0000,
    parameter int unsigned     TIMEOUT_CYCLES = 100000,
    parameter logic [XLEN-1:0] EXPECTED       = '0
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic                                                  start,
    output logic                                                  busy,
    output logic                                                  done,
    output logic                                                  timeout,
    output logic                                                  pass,
    output logic [CYCLES_W-1:0]                                   cycles,
    input  logic [$clog2(NUM_RESULTS > 1 ? NUM_RESULTS : 2)-1:0] result_sel,
    output logic [XLEN-1:0]                                       result_data
);

    localparam int              SEL_W = $clog2(NUM_RESULTS > 1 ? NUM_RESULTS : 2);
    localparam logic [XLEN-1:0] SPAN  = XLEN'(4 * NUM_RESULTS);

    bench_state_t      state;
    logic              launch, core_rst_n, soc_rst_n, ebreak, io_wen, capture;
    logic [XLEN-1:0]   io_waddr, io_wdata, offset;
    logic [XLEN/8-1:0] io_wstrb;
    logic [SEL_W-1:0]  slot_idx;
    logic [XLEN-1:0]   slots [NUM_RESULTS];

    svc_rv_bench_ctl #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ctl (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ebreak    (ebreak),
        .state     (state),
        .launch    (launch),
        .core_rst_n(core_rst_n),
        .cycles    (cycles)
    );

    // Harness reset reaches the core immediately, not one edge later.
    assign soc_rst_n = core_rst_n && rst_n;

    svc_rv_soc_sram #(
        .XLEN       (XLEN),
        .IMEM_AW    (IMEM_AW),
        .DMEM_AW    (DMEM_AW),
        .PIPELINED  (PIPELINED),
        .FWD_REGFILE(FWD_REGFILE),
        .FWD        (FWD),
        .BPRED      (BPRED),
        .IMEM_INIT  (IMEM_INIT)
    ) u_soc (
        .clk     (clk),
        .rst_n   (soc_rst_n),
        .ebreak  (ebreak),
        .io_wen  (io_wen),
        .io_waddr(io_waddr),
        .io_wstrb(io_wstrb),
        .io_wdata(io_wdata),
        .io_rdata('0)
    );

    // Addresses below the base wrap to a huge offset and fall out of range.
    assign offset   = io_waddr - XLEN'(RESULT_BASE);
    assign capture  = (state == RUN) && io_wen && (offset < SPAN);
    assign slot_idx = offset[SEL_W+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_RESULTS; s++) slots[s] <= '0;
        end else if (launch) begin
            for (int s = 0; s < NUM_RESULTS; s++) slots[s] <= '0;
        end else if (capture) begin
            for (int b = 0; b < XLEN / 8; b++) begin
                if (io_wstrb[b]) slots[slot_idx][8*b +: 8] <= io_wdata[8*b +: 8];
            end
        end
    end

    assign result_data = slots[result_sel];
    assign busy        = (state == RUN);
    assign done        = (state == DONE);
    assign timeout     = (state == TIMEOUT);

`ifdef SVC_RV_SOC_BENCH_CHECK_EN
    assign pass = (state == DONE) && (slots[0] == EXPECTED);
`else
    assign pass = 1'b0;
`endif

endmodule

// File: tb/tb_svc_rv_soc_sram_bench.sv
// Directed bench: three harness instances (store/ebreak, infinite loop with a
// short limit, byte-lane and range capture) driven from one linear sequence.
module tb_svc_rv_soc_sram_bench;

`ifdef SVC_RV_SOC_BENCH_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clk, rst_n;
    logic        start_a, busy_a, done_a, timeout_a, pass_a;
    logic        start_t, busy_t, done_t, timeout_t, pass_t;
    logic        start_c, busy_c, done_c, timeout_c, pass_c;
    logic [31:0] cycles_a, cycles_t, cycles_c, data_a, data_t, data_c;
    logic [1:0]  sel_a, sel_t, sel_c;

    int n_tests = 0;
    int n_fail  = 0;

    svc_rv_soc_sram_bench #(.EXPECTED(32'h1234_5678)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .timeout(timeout_a), .pass(pass_a), .cycles(cycles_a),
        .result_sel(sel_a), .result_data(data_a)
    );

    svc_rv_soc_sram_bench #(.TIMEOUT_CYCLES(64), .EXPECTED(32'h0)) u_t (
        .clk(clk), .rst_n(rst_n), .start(start_t), .busy(busy_t), .done(done_t),
        .timeout(timeout_t), .pass(pass_t), .cycles(cycles_t),
        .result_sel(sel_t), .result_data(data_t)
    );

    svc_rv_soc_sram_bench #(.RESULT_BASE(32'h20), .EXPECTED(32'h1234_5678)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .busy(busy_c), .done(done_c),
        .timeout(timeout_c), .pass(pass_c), .cycles(cycles_c),
        .result_sel(sel_c), .result_data(data_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0; start_t = 1'b0; start_c = 1'b0;
        sel_a   = 2'd0; sel_t   = 2'd0; sel_c   = 2'd0;

        for (int i = 0; i < 32; i++) begin
            u_a.u_soc.imem[i] = 32'h0;
            u_t.u_soc.imem[i] = 32'h0;
            u_c.u_soc.imem[i] = 32'h0;
        end
        // lui x1,0x12345; addi x1,x1,0x678; sw x1,0(x0); ebreak
        u_a.u_soc.imem[0] = 32'h1234_50B7;
        u_a.u_soc.imem[1] = 32'h6780_8093;
        u_a.u_soc.imem[2] = 32'h0010_2023;
        u_a.u_soc.imem[3] = 32'h0010_0073;
        // jal x0,0
        u_t.u_soc.imem[0] = 32'h0000_006F;
        // addi x2,x0,0xAB; sw 0x28; sb 0x25; sw 0x30; sw 0x1C; ebreak
        u_c.u_soc.imem[0] = 32'h0AB0_0113;
        u_c.u_soc.imem[1] = 32'h0220_2423;
        u_c.u_soc.imem[2] = 32'h0220_02A3;
        u_c.u_soc.imem[3] = 32'h0220_2823;
        u_c.u_soc.imem[4] = 32'h0020_2E23;
        u_c.u_soc.imem[5] = 32'h0010_0073;

        repeat (2) @(negedge clk);
        check("rst_busy", busy_a, 1'b0);
        check("rst_cycles", cycles_a, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy_a, 1'b0);
        check("idle_done", done_a, 1'b0);
        check("idle_timeout", timeout_t, 1'b0);
        check("idle_pass", pass_a, 1'b0);
        check("idle_data", data_a, 32'd0);

        // Store + ebreak run
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        check("a_busy", busy_a, 1'b1);
        check("a_cycles_cleared", cycles_a, 32'd0);
        check("a_pass_in_run", pass_a, 1'b0);
        for (int i = 0; i < 50 && !done_a; i++) @(negedge clk);
        check("a_done", done_a, 1'b1);
        check("a_busy_end", busy_a, 1'b0);
        check("a_timeout", timeout_a, 1'b0);
        check("a_cycles", cycles_a, 32'd4);
        check("a_slot0", data_a, 32'h1234_5678);
        check("a_pass", pass_a, CHECK_EN);

        // Restart from DONE
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        check("a2_cycles_cleared", cycles_a, 32'd0);
        check("a2_slot_cleared", data_a, 32'd0);
        check("a2_busy", busy_a, 1'b1);
        for (int i = 0; i < 50 && !done_a; i++) @(negedge clk);
        check("a2_done", done_a, 1'b1);
        check("a2_cycles", cycles_a, 32'd4);
        check("a2_slot0", data_a, 32'h1234_5678);

        // Timeout run, with a start pulse mid-run that must be ignored
        start_t = 1'b1; @(negedge clk); start_t = 1'b0;
        check("t_busy", busy_t, 1'b1);
        repeat (10) @(negedge clk);
        start_t = 1'b1; @(negedge clk); start_t = 1'b0;
        for (int i = 0; i < 200 && !timeout_t; i++) @(negedge clk);
        check("t_timeout", timeout_t, 1'b1);
        check("t_done", done_t, 1'b0);
        check("t_busy_end", busy_t, 1'b0);
        check("t_cycles", cycles_t, 32'd64);
        check("t_pass", pass_t, 1'b0);
        repeat (3) @(negedge clk);
        check("t_cycles_frozen", cycles_t, 32'd64);

        // Byte lanes, base offset and range filtering
        start_c = 1'b1; @(negedge clk); start_c = 1'b0;
        for (int i = 0; i < 50 && !done_c; i++) @(negedge clk);
        check("c_done", done_c, 1'b1);
        check("c_cycles", cycles_c, 32'd6);
        check("c_pass", pass_c, 1'b0);
        sel_c = 2'd0; #1 check("c_slot0", data_c, 32'h0000_0000);
        sel_c = 2'd1; #1 check("c_slot1", data_c, 32'h0000_AB00);
        sel_c = 2'd2; #1 check("c_slot2", data_c, 32'h0000_00AB);
        sel_c = 2'd3; #1 check("c_slot3", data_c, 32'h0000_0000);
        sel_c = 2'd1;

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        start_t = 1'b1; @(negedge clk); start_t = 1'b0;
        repeat (10) @(negedge clk);
        check("r_busy_before", busy_t, 1'b1);
        check("r_cycles_before", cycles_t, 32'd10);
        rst_n = 1'b0;
        #1;
        check("r_busy", busy_t, 1'b0);
        check("r_cycles", cycles_t, 32'd0);
        check("r_timeout", timeout_t, 1'b0);
        check("r_done_a", done_a, 1'b0);
        check("r_slot_a", data_a, 32'd0);
        check("r_slot_c", data_c, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("r_idle_busy", busy_t, 1'b0);
        check("r_idle_cycles", cycles_t, 32'd0);

        // Core restarts cleanly after reset
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        for (int i = 0; i < 50 && !done_a; i++) @(negedge clk);
        check("p_done", done_a, 1'b1);
        check("p_cycles", cycles_a, 32'd4);
        check("p_slot0", data_a, 32'h1234_5678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
